// File: rtl/bram_avg_pkg.sv
// Shared types and defaults for the BRAM averaging reader.
//   state_t   : controller states (Idle, Issue, Drain)
//   acc_width : accumulator width needed to sum 2**log2_n words of data_w bits
//   Def*      : default parameter values of bram_avg_reader
package bram_avg_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Issue = 2'd1,
    Drain = 2'd2
  } state_t;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefLog2N = 3;
  localparam int unsigned DefRdLat = 2;

  // A sum of 2**log2_n words never exceeds data_w + log2_n bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/bram_rd_valid_pipe.sv
// Delay line that tracks which BRAM read-data cycles carry valid data.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset, flushes the pipe
//   valid_i : read enable issued to the BRAM this cycle
//   valid_o : valid_i delayed by DEPTH cycles (aligned with read data)
module bram_rd_valid_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_avg_reader.sv
// Streams 2**LOG2_N consecutive words from a synchronous-read BRAM (one read per
// cycle, address wraps), sums them and reports the sum and the average with a
// one-cycle valid pulse.
// Optional build macro BRAM_AVG_ROUND_EN: average rounds half up instead of
// truncating; sum and timing are unchanged.
// Ports:
//   clk_i       : clock (rising edge)
//   rst_i       : synchronous active-high reset, aborts a run in progress
//   start_i     : start request, only sampled while idle
//   base_addr_i : first read address, captured on start
//   busy_o      : run in progress
//   rd_en_o     : BRAM read enable
//   rd_addr_o   : BRAM read address
//   rd_data_i   : BRAM read data, valid RD_LAT cycles after rd_en_o
//   sum_o       : sum of the last run
//   avg_o       : average of the last run
//   avg_valid_o : one-cycle pulse when sum_o / avg_o update
module bram_avg_reader
  import bram_avg_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LOG2_N = DefLog2N,  // 0 .. ADDR_W
  parameter int unsigned RD_LAT = DefRdLat,  // >= 1
  localparam int unsigned ACC_W = acc_width(DATA_W, LOG2_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o
);

  localparam int unsigned N       = 2 ** LOG2_N;
  localparam int unsigned CntW    = LOG2_N + 1;
  localparam int unsigned LatCntW = $clog2(RD_LAT + 1);
  // Half an LSB of the average; zero when LOG2_N = 0.
  localparam logic [ACC_W-1:0] RoundAdd = ACC_W'(N / 2);

  state_t              state_q;
  logic [CntW-1:0]     issue_cnt_q;
  logic [LatCntW-1:0]  drain_cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sum_q;
  logic [DATA_W-1:0]   avg_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q;
  logic                rd_en_q;
  logic                avg_valid_q;

  logic                data_vld;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    avg_sum;

  bram_rd_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_vld_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(rd_en_q),
    .valid_o(data_vld)
  );

  // acc_d includes the sample arriving this cycle, so the completion edge can
  // publish the final sum directly.
  always_comb begin
    acc_d = acc_q;
    if (data_vld) begin
      acc_d = acc_q + ACC_W'(rd_data_i);
    end
`ifdef BRAM_AVG_ROUND_EN
    avg_sum = acc_d + RoundAdd;
`else
    avg_sum = acc_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      acc_q       <= acc_d;
      unique case (state_q)
        Idle: begin
          if (start_i) begin
            state_q     <= Issue;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= base_addr_i;
            issue_cnt_q <= CntW'(1);  // counts the read being issued next cycle
            acc_q       <= '0;
          end
        end
        Issue: begin
          if (issue_cnt_q == CntW'(N)) begin
            state_q     <= Drain;
            rd_en_q     <= 1'b0;
            drain_cnt_q <= LatCntW'(1);
          end else begin
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            issue_cnt_q <= issue_cnt_q + CntW'(1);
          end
        end
        Drain: begin
          if (drain_cnt_q == LatCntW'(RD_LAT)) begin
            state_q     <= Idle;
            busy_q      <= 1'b0;
            sum_q       <= acc_d;
            avg_q       <= DATA_W'(avg_sum >> LOG2_N);
            avg_valid_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + LatCntW'(1);
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign sum_o       = sum_q;
  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;

endmodule

// File: tb/tb_bram_avg_reader.sv
// Self-checking bench for bram_avg_reader. Three parameter sets run side by
// side, each with its own BRAM model and DUT; expected sums/averages come from
// summing the BRAM contents over the wrapped address window.
module tb_bram_avg_reader;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 3;
  localparam int unsigned NCFG = 3;
  localparam int unsigned L_TAB [NCFG] = '{3, 0, 2};
  localparam int unsigned R_TAB [NCFG] = '{2, 1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned L    = L_TAB[g];
    localparam int unsigned RD   = R_TAB[g];
    localparam int unsigned N    = 1 << L;
    localparam int unsigned AccW = DW + L;

    logic            rst, start, busy, rd_en, avg_valid;
    logic [AW-1:0]   base, rd_addr;
    logic [DW-1:0]   rd_data, avg;
    logic [AccW-1:0] sum;
    logic [DW-1:0]   mem   [8];
    logic [DW-1:0]   lat_q [RD];
    logic [63:0]     last_sum, last_avg;
    logic            done_f;

    bram_avg_reader #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .LOG2_N(L),
      .RD_LAT(RD)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .base_addr_i(base),
      .busy_o     (busy),
      .rd_en_o    (rd_en),
      .rd_addr_o  (rd_addr),
      .rd_data_i  (rd_data),
      .sum_o      (sum),
      .avg_o      (avg),
      .avg_valid_o(avg_valid)
    );

    // BRAM model: garbage on the data bus whenever no read was issued.
    always @(posedge clk) begin
      lat_q[0] <= rd_en ? mem[rd_addr] : DW'($urandom);
      for (int i = 1; i < RD; i++) lat_q[i] <= lat_q[i-1];
    end
    assign rd_data = lat_q[RD-1];

    function automatic logic [63:0] exp_sum(input int unsigned b);
      logic [63:0] s = 0;
      for (int k = 0; k < N; k++) s += 64'(mem[(b + k) % 8]);
      return s;
    endfunction

    function automatic logic [63:0] exp_avg(input logic [63:0] s);
`ifdef BRAM_AVG_ROUND_EN
      return (s + 64'(N / 2)) >> L;
`else
      return s >> L;
`endif
    endfunction

    function automatic string tg(input string what, input int c);
      return $sformatf("c%0d.%s.%0d", g, what, c);
    endfunction

    task automatic reset_check(input int c);
      check_eq(tg("rst.busy", c), 64'(busy), 0);
      check_eq(tg("rst.rd_en", c), 64'(rd_en), 0);
      check_eq(tg("rst.rd_addr", c), 64'(rd_addr), 0);
      check_eq(tg("rst.sum", c), 64'(sum), 0);
      check_eq(tg("rst.avg", c), 64'(avg), 0);
      check_eq(tg("rst.avg_valid", c), 64'(avg_valid), 0);
    endtask

    // Entry: inside cycle 0 before its rising edge. Exit: negedge of the
    // avg_valid cycle, with start driven to 'hold' in that cycle.
    task automatic run_one(input int unsigned b, input bit noise, input bit hold);
      logic [63:0] es, ea;
      es    = exp_sum(b);
      ea    = exp_avg(es);
      start = 1'b1;
      base  = AW'(b);
      for (int c = 1; c <= int'(N + RD + 1); c++) begin
        @(posedge clk);
        #1;
        if (c <= int'(N + RD)) begin
          start = noise ? 1'($urandom % 2) : 1'b0;
          if (noise) base = AW'($urandom);
        end else begin
          start = hold;
        end
        @(negedge clk);
        check_eq(tg("busy", c), 64'(busy), 64'(c <= int'(N + RD)));
        check_eq(tg("rd_en", c), 64'(rd_en), 64'(c <= int'(N)));
        check_eq(tg("rd_addr", c), 64'(rd_addr),
                 64'((b + ((c <= int'(N)) ? c - 1 : N - 1)) % 8));
        check_eq(tg("avg_valid", c), 64'(avg_valid), 64'(c == int'(N + RD + 1)));
        if (c == int'(N + RD + 1)) begin
          check_eq(tg("sum", c), 64'(sum), es);
          check_eq(tg("avg", c), 64'(avg), ea);
        end
      end
      last_sum = es;
      last_avg = ea;
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq(tg("idle.busy", i), 64'(busy), 0);
        check_eq(tg("idle.avg_valid", i), 64'(avg_valid), 0);
        check_eq(tg("idle.sum", i), 64'(sum), last_sum);
        check_eq(tg("idle.avg", i), 64'(avg), last_avg);
      end
    endtask

    // Reset while the run is still busy; nothing of it may surface afterwards.
    task automatic run_reset(input int unsigned b);
      int r;
      r     = (N + RD >= 5) ? 5 : int'(N + RD);
      start = 1'b1;
      base  = AW'(b);
      for (int c = 1; c <= r; c++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (c == r) rst = 1'b1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      reset_check(r + 1);
      last_sum = 0;
      last_avg = 0;
      idle(RD + 2);
    endtask

    initial begin
      done_f   = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      base     = '0;
      last_sum = 0;
      last_avg = 0;
      for (int k = 0; k < 8; k++) mem[k] = DW'(k + 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_check(0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      // words 1..8, base 0
      run_one(0, 1'b0, 1'b0);
      idle(2);
      // words 10*k, base 6 (wrapping window)
      for (int k = 0; k < 8; k++) mem[k] = DW'(10 * k);
      run_one(6, 1'b0, 1'b0);
      idle(1);
      // full-scale words
      for (int k = 0; k < 8; k++) mem[k] = 16'hFFFF;
      run_one($urandom % 8, 1'b0, 1'b0);
      idle(1);
      // random contents, random start/base noise while busy
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 8; k++) mem[k] = DW'($urandom);
        run_one($urandom % 8, 1'b1, 1'b0);
        idle($urandom_range(1, 3));
      end
      // start held high: back-to-back runs with a one-cycle gap
      for (int k = 0; k < 8; k++) mem[k] = DW'($urandom);
      run_one($urandom % 8, 1'b0, 1'b1);
      run_one($urandom % 8, 1'b1, 1'b1);
      run_one($urandom % 8, 1'b0, 1'b0);
      idle(1);
      // abort mid-run, then a clean run
      run_reset($urandom % 8);
      for (int k = 0; k < 8; k++) mem[k] = DW'($urandom);
      run_one($urandom % 8, 1'b0, 1'b0);
      idle(1);
      done_f = 1'b1;
    end
  end

  initial begin
    logic all_done;
    all_done = 1'b0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_cfg[0].done_f & g_cfg[1].done_f & g_cfg[2].done_f;
    end
    check_eq("all_done", 64'(all_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
